mp_add_seq: RTL and testbench

//  Sequences one shared 16-bit ripple-carry adder slice (rca_16b) to add or subtract

---
 rtl/mp_add_seq_pkg.sv | 12 +
 rtl/mp_add_seq_if.sv | 30 +++
 rtl/mp_add_seq_rca_16b.sv | 23 ++
 rtl/mp_add_seq.sv | 107 ++++++++++
 tb/tb_mp_add_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mp_add_seq_pkg.sv
// rtl/mp_add_seq_pkg.sv - shared slice width and state encoding for mp_add_seq
package mp_add_seq_pkg;

  localparam int W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/mp_add_seq_if.sv
// rtl/mp_add_seq_if.sv - start/busy/done operand and result bundle for mp_add_seq
interface mp_add_seq_if
  import mp_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
);

  localparam int N = W * NWORDS;

  logic         start;
  logic         sub;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] S;
  logic         C_out;
  logic         Ofl;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, C_out, Ofl
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, C_out, Ofl
  );

endinterface

// File: rtl/mp_add_seq_rca_16b.sv
// rtl/mp_add_seq_rca_16b.sv - purely combinational 16-bit ripple-carry adder slice
module rca_16b
  import mp_add_seq_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         C_in,
  output logic [W-1:0] S,
  output logic         C_out
);

  always_comb begin
    logic cy;
    cy = C_in;
    S  = '0;
    for (int i = 0; i < W; i++) begin
      S[i] = A[i] ^ B[i] ^ cy;
      cy   = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
    C_out = cy;
  end

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - word-serial N-bit add/subtract over one shared rca_16b slice
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mp_add_seq_if.slave  bus
);

  localparam int N  = W * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [N-1:0]    s_q;
  logic            c_out_q;
  logic            ofl_q;

  logic            accept;
  logic            run_en;
  logic            last_word;
  logic [W-1:0]    word_a;
  logic [W-1:0]    word_b;
  logic [W-1:0]    sum;
  logic            slice_c;

  assign word_a = op_a[idx*W +: W];
  assign word_b = op_b[idx*W +: W];

  rca_16b u_slice (
    .A     (word_a),
    .B     (word_b),
    .C_in  (carry),
    .S     (sum),
    .C_out (slice_c)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    run_en     = 1'b0;
    last_word  = (idx == LAST);
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (last_word) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      state <= next_state;
      // Subtraction is A + ~B + 1: the +1 rides in on the initial carry.
      if (accept) begin
        op_a  <= bus.A;
        op_b  <= bus.sub ? ~bus.B : bus.B;
        carry <= bus.sub;
        idx   <= '0;
      end
      if (run_en) begin
        s_q[idx*W +: W] <= sum;
        carry           <= slice_c;
        if (last_word) begin
          c_out_q <= slice_c;
          ofl_q   <= (op_a[N-1] == op_b[N-1]) & (sum[W-1] != op_a[N-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.busy = (state == ST_RUN) || (state == ST_DONE);
    bus.done = (state == ST_DONE);
  end

  assign bus.S     = s_q;
  assign bus.C_out = c_out_q;
  assign bus.Ofl   = ofl_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - scoreboard bench for mp_add_seq with directed vectors
module tb_mp_add_seq;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  mp_add_seq_if #(.NWORDS(4)) bus ();

  mp_add_seq #(.NWORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present start for one cycle; expected done cycle is the start cycle + NWORDS + 1.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sb_sub,
                       input logic push, input logic [63:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.sub   = sb_sub;
    bus.start = 1'b1;
    if (push) begin
      e.s   = es;
      e.c   = ec;
      e.o   = eo;
      e.cyc = cyc + 5;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = {$urandom, $urandom};
    bus.B     = {$urandom, $urandom};
    bus.sub   = ~sb_sub;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(bus.busy), 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("S", bus.S, e.s);
        chk("C_out", 64'(bus.C_out), 64'(e.c));
        chk("Ofl", 64'(bus.Ofl), 64'(e.o));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_S", bus.S, 64'd0);
    chk("rst_C_out", 64'(bus.C_out), 64'd0);
    chk("rst_Ofl", 64'(bus.Ofl), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    wait_idle();
    issue(64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    wait_idle();
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    wait_idle();
    issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, 64'h1_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("carry_after_word0", 64'(dut.carry), 64'd1);
    chk("idx_after_word0", 64'(dut.idx), 64'd1);
    wait_idle();

    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
          64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    bus.A     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.B     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    issue(64'hDEAD_BEEF_0000_1111, 64'h2222, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_rst_busy", 64'(bus.busy), 64'd0);
    chk("midop_rst_S", bus.S, 64'd0);
    chk("midop_rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(64'h5, 64'h3, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
